fetch_queue: RTL and testbench

- Consumer side of the program counter interface.
- Takes each fetch address the PC presents, issues it to instruction memory, and tracks in-flight requests in an in-order queue.
- Delivers {instr, pc, pc_plus4} to decode with a valid/ready handshake.
- Drives the PC's stall input and honours the PC's registered flush flag by squashing wrong-path fetches, including responses still in flight.

---
 rtl/fetch_queue_pkg.sv | 16 +
 rtl/fetch_entry_ram.sv | 41 ++++
 rtl/fetch_queue.sv | 125 ++++++++++++
 tb/tb_fetch_queue.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-side types: instruction word, boot vector, queue entry.
package fetch_queue_pkg;

  typedef logic [31:0] word;

  localparam word BOOT_ADDRESS = 32'h0000_0000;
  localparam int  FETCH_DEPTH  = 4;

  typedef struct packed {
    word  pc;
    word  pc_plus4;
    word  instr;
    logic filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_ram.sv
// Fetch queue storage: one alloc write port, one fill port, async head read.
module fetch_entry_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_wr_en,
  input  logic [PTR_W-1:0]   i_wr_idx,
  input  fetch_entry_t       i_wr_data,
  input  logic               i_fill_en,
  input  logic [PTR_W-1:0]   i_fill_idx,
  input  word                i_fill_instr,
  input  logic [PTR_W-1:0]   i_rd_idx,
  output fetch_entry_t       o_rd_data
);

  fetch_entry_t r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Fill and alloc never target the same live slot.
      if (i_fill_en) begin
        r_mem[i_fill_idx].instr  <= i_fill_instr;
        r_mem[i_fill_idx].filled <= 1'b1;
      end
      if (i_wr_en) begin
        r_mem[i_wr_idx] <= i_wr_data;
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/fetch_queue.sv
// In-order fetch queue between PC and decode; squashes wrong-path
// fetches on redirect, including responses still in flight.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic clock,
  input  logic reset,
  input  word  pc_addr,
  input  word  pc_plus4,
  input  logic pc_flush,
  output logic fetch_stall,
  output logic imem_req_valid,
  input  logic imem_req_ready,
  output word  imem_addr,
  input  logic imem_resp_valid,
  input  word  imem_resp_data,
  output logic out_valid,
  input  logic out_ready,
  output word  out_instr,
  output word  out_pc,
  output word  out_pc_plus4
);

  localparam int CW = PTR_W + 1;
  localparam int SW = PTR_W + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_alloc;
  logic [PTR_W-1:0] r_fill;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_unfilled;
  logic [CW-1:0]    r_drop;

  logic [SW-1:0]    w_sum;
  logic [SW-1:0]    w_daf;
  logic             w_room;
  logic             w_push;
  logic             w_pop;
  logic             w_resp_drop;
  logic             w_resp_fill;
  logic [PTR_W-1:0] w_wr_idx;
  fetch_entry_t     w_wr_data;
  fetch_entry_t     w_head;

  always_comb begin
    // Outstanding responses, live or orphaned, bound new requests.
    w_sum  = SW'(r_drop) + SW'(r_unfilled);
    w_daf  = w_sum - SW'(imem_resp_valid);
    w_room = pc_flush ? (w_daf < DEPTH_S)
                      : (w_sum < DEPTH_S);
    imem_req_valid = !reset && w_room &&
                     (pc_flush || r_count < DEPTH_C);
    w_push      = imem_req_valid && imem_req_ready;
    fetch_stall = !w_push;
    imem_addr   = pc_addr;
    w_resp_drop = imem_resp_valid && r_drop != '0;
    w_resp_fill = imem_resp_valid && r_drop == '0 &&
                  !pc_flush;
    w_wr_idx    = pc_flush ? '0 : r_alloc;
    w_wr_data   = '{pc:       pc_addr,
                    pc_plus4: pc_plus4,
                    instr:    '0,
                    filled:   1'b0};
    out_valid    = !reset && !pc_flush &&
                   r_count != '0 && w_head.filled;
    w_pop        = out_valid && out_ready;
    out_instr    = w_head.instr;
    out_pc       = w_head.pc;
    out_pc_plus4 = w_head.pc_plus4;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      r_drop     <= '0;
    end else if (pc_flush) begin
      // Everything allocated becomes an orphan; redirect lands in slot 0.
      r_head     <= '0;
      r_fill     <= '0;
      r_alloc    <= PTR_W'(w_push);
      r_count    <= CW'(w_push);
      r_unfilled <= CW'(w_push);
      r_drop     <= w_daf[CW-1:0];
    end else begin
      r_head     <= r_head + PTR_W'(w_pop);
      r_alloc    <= r_alloc + PTR_W'(w_push);
      r_fill     <= r_fill + PTR_W'(w_resp_fill);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_unfilled <= r_unfilled + CW'(w_push)
                    - CW'(w_resp_fill);
      r_drop     <= r_drop - CW'(w_resp_drop);
    end
  end

  fetch_entry_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clock        (clock),
    .reset        (reset),
    .i_wr_en      (w_push),
    .i_wr_idx     (w_wr_idx),
    .i_wr_data    (w_wr_data),
    .i_fill_en    (w_resp_fill),
    .i_fill_idx   (r_fill),
    .i_fill_instr (imem_resp_data),
    .i_rd_idx     (r_head),
    .o_rd_data    (w_head)
  );

  a_resp_expected: assert property (
    @(posedge clock) disable iff (reset)
    !(imem_resp_valid && r_unfilled == '0 &&
      r_drop == '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue with a PC, imem and delivery model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = FETCH_DEPTH;

  logic clock = 1'b0;
  logic reset;
  word  pc_addr, pc_plus4;
  logic pc_flush;
  logic fetch_stall;
  logic imem_req_valid, imem_req_ready;
  word  imem_addr;
  logic imem_resp_valid;
  word  imem_resp_data;
  logic out_valid, out_ready;
  word  out_instr, out_pc, out_pc_plus4;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc_addr         (pc_addr),
    .pc_plus4        (pc_plus4),
    .pc_flush        (pc_flush),
    .fetch_stall     (fetch_stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4)
  );

  always #5 clock = ~clock;

  // Outstanding imem requests (in order) and queued instructions.
  typedef struct { word data; int due; bit live; int id; } req_t;
  typedef struct { word pc; word pc4; word instr; bit filled; int id; } ent_t;

  req_t mq[$];
  ent_t dq[$];
  word  pc_m;
  bit   fl_m;
  int   cyc, next_id;
  int   k_ready, k_oready, k_lat_lo, k_lat_hi, k_resp;
  bit   k_reset;
  bit   e_req, e_ov, e_resp;
  ent_t e_head;
  bit   last_acc;
  word  last_addr, last_data;
  int   n_checks, n_fail;

  task automatic set_knobs(int rdy, int ordy, int lo, int hi, int rsp);
    k_ready = rdy; k_oready = ordy;
    k_lat_lo = lo; k_lat_hi = hi; k_resp = rsp;
  endtask

  task automatic drive();
    int outst;
    @(negedge clock);
    reset          = k_reset;
    pc_addr        = pc_m;
    pc_plus4       = pc_m + 32'd4;
    pc_flush       = fl_m;
    imem_req_ready = ($urandom_range(99) < k_ready);
    e_resp = !k_reset && mq.size() > 0 && mq[0].due <= cyc &&
             ($urandom_range(99) < k_resp);
    imem_resp_valid = e_resp;
    imem_resp_data  = e_resp ? mq[0].data : $urandom;
    out_ready       = ($urandom_range(99) < k_oready);
    if (k_reset) begin
      e_req = 1'b0;
      e_ov  = 1'b0;
    end else begin
      outst = mq.size() - ((fl_m && e_resp) ? 1 : 0);
      e_req = outst < DEPTH && (fl_m || dq.size() < DEPTH);
      e_ov  = !fl_m && dq.size() > 0 && dq[0].filled;
    end
    if (dq.size() > 0) e_head = dq[0];
    #1;
  endtask

  task automatic advance();
    req_t r;
    ent_t n;
    last_acc = e_req && imem_req_ready;
    if (k_reset) begin
      mq.delete();
      dq.delete();
      pc_m = BOOT_ADDRESS;
      fl_m = 1'b0;
      last_acc = 1'b0;
    end else begin
      if (fl_m) begin
        foreach (mq[i]) mq[i].live = 1'b0;
        dq.delete();
      end
      if (e_ov && out_ready) void'(dq.pop_front());
      if (e_resp) begin
        r = mq.pop_front();
        if (r.live) begin
          foreach (dq[i]) begin
            if (dq[i].id == r.id) begin
              dq[i].instr  = r.data;
              dq[i].filled = 1'b1;
            end
          end
        end
      end
      if (last_acc) begin
        r.data = $urandom;
        r.due  = cyc + int'($urandom_range(k_lat_hi, k_lat_lo));
        r.live = 1'b1;
        r.id   = next_id;
        n.pc = pc_m; n.pc4 = pc_m + 32'd4;
        n.instr = '0; n.filled = 1'b0; n.id = next_id;
        next_id++;
        mq.push_back(r);
        dq.push_back(n);
        last_addr = pc_m;
        last_data = r.data;
        pc_m = pc_m + 32'd4;
        fl_m = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) begin
      drive();
      advance();
    end
  endtask

  task automatic do_reset();
    k_reset = 1'b1;
    run(2);
    k_reset = 1'b0;
  endtask

  task automatic test_reset();
    set_knobs(100, 100, 1, 1, 100);
    k_reset = 1'b1;
    drive();
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid);
    end
    n_checks++;
    if (fetch_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall got=%b exp=1", fetch_stall);
    end
    advance();
    k_reset = 1'b0;
    drive();
    n_checks++;
    if ({out_valid, out_instr, out_pc, out_pc_plus4} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_out got v=%b i=%h pc=%h p4=%h exp all 0",
               out_valid, out_instr, out_pc, out_pc_plus4);
    end
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== BOOT_ADDRESS) begin
      n_fail++;
      $display("FAIL post_reset_req got v=%b a=%h exp v=1 a=%h",
               imem_req_valid, imem_addr, BOOT_ADDRESS);
    end
    advance();
  endtask

  task automatic test_sequential();
    word nxt;
    int  nd;
    do_reset();
    set_knobs(100, 100, 1, 1, 100);
    nxt = BOOT_ADDRESS;
    nd  = 0;
    for (int i = 0; i < 24; i++) begin
      drive();
      n_checks++;
      if (imem_req_valid !== e_req) begin
        n_fail++;
        $display("FAIL seq_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, e_req);
      end
      n_checks++;
      if (fetch_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_stall cyc=%0d got=%b exp=0", cyc, fetch_stall);
      end
      n_checks++;
      if (out_valid !== e_ov) begin
        n_fail++;
        $display("FAIL seq_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_ov);
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_pc !== nxt || out_pc_plus4 !== nxt + 32'd4 ||
            out_instr !== e_head.instr) begin
          n_fail++;
          $display("FAIL seq_order got pc=%h p4=%h i=%h exp pc=%h p4=%h i=%h",
                   out_pc, out_pc_plus4, out_instr, nxt, nxt + 32'd4, e_head.instr);
        end
        nxt = nxt + 32'd4;
        nd++;
      end
      advance();
    end
    n_checks++;
    if (nd !== 22) begin
      n_fail++;
      $display("FAIL seq_count got=%0d exp=22", nd);
    end
  endtask

  task automatic test_backpressure();
    int  acc, nd;
    bit  seen;
    word nxt;
    do_reset();
    set_knobs(100, 0, 1, 1, 100);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive();
      if (imem_req_valid && imem_req_ready) acc++;
      advance();
    end
    n_checks++;
    if (acc !== DEPTH) begin
      n_fail++;
      $display("FAIL bp_accepts got=%0d exp=%0d", acc, DEPTH);
    end
    drive();
    n_checks++;
    if (fetch_stall !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full got stall=%b v=%b exp stall=1 v=0",
               fetch_stall, imem_req_valid);
    end
    advance();
    k_oready = 100;
    nxt = 32'h0; nd = 0; seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive();
      if (i == 0) begin
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_no_bypass got=%b exp=0", imem_req_valid);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_pc !== nxt) begin
          n_fail++;
          $display("FAIL bp_drain got=%h exp=%h", out_pc, nxt);
        end
        nxt = nxt + 32'd4;
        nd++;
      end
      if (imem_req_valid && imem_req_ready && !seen) begin
        seen = 1'b1;
        n_checks++;
        if (imem_addr !== 32'h10) begin
          n_fail++;
          $display("FAIL bp_resume got=%h exp=00000010", imem_addr);
        end
      end
      advance();
    end
    n_checks++;
    if (nd !== 14) begin
      n_fail++;
      $display("FAIL bp_count got=%0d exp=14", nd);
    end
  endtask

  // Redirect to tgt after pre cycles; flush held for hold cycles with
  // imem not ready; then check the delivered stream starts at tgt.
  task automatic test_flush(string nm, int lat, int pre, int hold, word tgt);
    word d, nxt;
    bit  have;
    int  nd;
    do_reset();
    set_knobs(100, 100, lat, lat, 100);
    run(pre);
    pc_m = tgt;
    fl_m = 1'b1;
    have = 1'b0; nd = 0; nxt = tgt; d = '0;
    for (int i = 0; i < 20; i++) begin
      k_ready = (i < hold) ? 0 : 100;
      drive();
      if (pc_flush) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_squash cyc=%0d got=%b exp=0", nm, cyc, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_pc !== nxt || (nd == 0 && out_instr !== d)) begin
          n_fail++;
          $display("FAIL %s_deliver got pc=%h i=%h exp pc=%h i=%h",
                   nm, out_pc, out_instr, nxt, d);
        end
        nxt = nxt + 32'd4;
        nd++;
      end
      advance();
      if (last_acc && last_addr == tgt && !have) begin
        have = 1'b1;
        d    = last_data;
      end
    end
    n_checks++;
    if (nd < 3) begin
      n_fail++;
      $display("FAIL %s_count got=%0d exp>=3", nm, nd);
    end
  endtask

  task automatic test_reset_midstream();
    bit got;
    do_reset();
    set_knobs(100, 0, 1, 1, 100);
    run(3);
    drive();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_pre got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc);
    end
    advance();
    k_reset = 1'b1;
    run(1);
    k_reset = 1'b0;
    drive();
    n_checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 ||
        imem_addr !== BOOT_ADDRESS) begin
      n_fail++;
      $display("FAIL mid_post got ov=%b rv=%b a=%h exp ov=0 rv=1 a=%h",
               out_valid, imem_req_valid, imem_addr, BOOT_ADDRESS);
    end
    advance();
    k_oready = 100;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive();
      if (out_valid && out_ready && !got) begin
        got = 1'b1;
        n_checks++;
        if (out_pc !== BOOT_ADDRESS || out_instr !== e_head.instr) begin
          n_fail++;
          $display("FAIL mid_restart got pc=%h i=%h exp pc=%h i=%h",
                   out_pc, out_instr, BOOT_ADDRESS, e_head.instr);
        end
      end
      advance();
    end
    n_checks++;
    if (got !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_timeout got=0 exp=1");
    end
  endtask

  task automatic test_random();
    do_reset();
    set_knobs(70, 60, 1, 4, 75);
    for (int i = 0; i < 3000; i++) begin
      if (!fl_m && $urandom_range(99) < 3) begin
        pc_m = word'($urandom) & 32'hFFFF_FFFC;
        fl_m = 1'b1;
      end
      k_reset = ($urandom_range(499) == 0);
      drive();
      n_checks++;
      if (imem_req_valid !== e_req) begin
        n_fail++;
        $display("FAIL rnd_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, e_req);
      end
      n_checks++;
      if (fetch_stall !== !(e_req && imem_req_ready)) begin
        n_fail++;
        $display("FAIL rnd_stall cyc=%0d got=%b exp=%b",
                 cyc, fetch_stall, !(e_req && imem_req_ready));
      end
      if (e_req) begin
        n_checks++;
        if (imem_addr !== pc_m) begin
          n_fail++;
          $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, pc_m);
        end
      end
      n_checks++;
      if (out_valid !== e_ov) begin
        n_fail++;
        $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_ov);
      end
      if (e_ov) begin
        n_checks++;
        if (out_pc !== e_head.pc || out_pc_plus4 !== e_head.pc4 ||
            out_instr !== e_head.instr) begin
          n_fail++;
          $display("FAIL rnd_out cyc=%0d got %h/%h/%h exp %h/%h/%h", cyc,
                   out_pc, out_pc_plus4, out_instr,
                   e_head.pc, e_head.pc4, e_head.instr);
        end
      end
      advance();
    end
    k_reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc_addr = '0; pc_plus4 = 32'd4; pc_flush = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = '0; out_ready = 1'b0;
    pc_m = BOOT_ADDRESS; fl_m = 1'b0; cyc = 0; next_id = 0;
    k_reset = 1'b1; n_checks = 0; n_fail = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_flush("fl_inflight", 5, 3, 0, 32'h100);
    test_flush("fl_stalled", 3, 2, 2, 32'h100);
    test_flush("fl_resp", 2, 2, 0, 32'h200);
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
